// File: rtl/regfile_scoreboard_pkg.sv
// Shared sizing for the 32x32 register file and its pending-write scoreboard.
// Register 0 is hard-wired to zero, so at most 31 writes can be pending at once.
package regfile_scoreboard_pkg;
  localparam int WIDTH = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int CNT_W = 6;

  localparam logic [AW-1:0]    REG_ZERO = 5'd0;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NREGS - 1);

  function automatic logic [NREGS-1:0] addr_onehot(input logic [AW-1:0] a);
    return NREGS'(1) << a;
  endfunction
endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback-facing bus of the register file: two read ports, writeback, reserve and hazard flags.
// The master is the decode/writeback side; the slave is the register file.
interface regfile_scoreboard_if;
  import regfile_scoreboard_pkg::*;

  logic [AW-1:0]    read_addr1;
  logic [AW-1:0]    read_addr2;
  logic [WIDTH-1:0] read_data1;
  logic [WIDTH-1:0] read_data2;
  logic             write_en;
  logic [AW-1:0]    write_addr;
  logic [WIDTH-1:0] write_data;
  logic             reserve_en;
  logic [AW-1:0]    reserve_addr;
  logic             busy1;
  logic             busy2;
  logic             reserve_conflict;
  logic [CNT_W-1:0] pending_count;

  modport master (
    output read_addr1, read_addr2, write_en, write_addr, write_data, reserve_en, reserve_addr,
    input  read_data1, read_data2, busy1, busy2, reserve_conflict, pending_count
  );

  modport slave (
    input  read_addr1, read_addr2, write_en, write_addr, write_data, reserve_en, reserve_addr,
    output read_data1, read_data2, busy1, busy2, reserve_conflict, pending_count
  );
endinterface

// File: rtl/mux32to1by32.sv
// 32-way word select for one register-file read port; purely combinational, no backpressure.
// Word 0 is expected to be driven as constant zero by the instantiating block.
module mux32to1by32 #(
  parameter int WIDTH = 32
) (
  input  logic [31:0][WIDTH-1:0] i_words,
  input  logic [4:0]             i_sel,
  output logic [WIDTH-1:0]       o_y
);
  assign o_y = i_words[i_sel];
endmodule

// File: rtl/register32_we.sv
// One WIDTH-bit storage word with write enable; 1-cycle write latency, no backpressure.
// Asynchronous active-high reset clears the word.
module register32_we #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_we) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;
endmodule

// File: rtl/regfile_scoreboard.sv
// 32x32 register file (2 comb read ports, 1 sync write port) with a pending-write scoreboard; no backpressure,
// decode stalls on busy1/busy2/reserve_conflict. Optional write-through bypass: REGFILE_BYPASS_EN.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
(
  input logic               clk,
  input logic               reset,
  regfile_scoreboard_if.slave bus
);
  logic [NREGS-1:0]            w_we_onehot;
  logic [NREGS-1:0]            w_rsv_onehot;
  logic [NREGS-1:0][WIDTH-1:0] w_words;
  logic [WIDTH-1:0]            w_mux1;
  logic [WIDTH-1:0]            w_mux2;
  logic                        w_wr_valid;
  logic                        w_rsv_hit_wr;
  logic                        w_conflict;
  logic                        w_rsv_accept;
  logic                        w_clear_set;
  logic                        w_byp1;
  logic                        w_byp2;
  logic [NREGS-1:0]            r_busy;
  logic [CNT_W-1:0]            r_count;

  assign w_wr_valid  = bus.write_en & (bus.write_addr != REG_ZERO);
  assign w_we_onehot = w_wr_valid ? addr_onehot(bus.write_addr) : '0;

  assign w_words[0] = '0;
  for (genvar gi = 1; gi < NREGS; gi++) begin : g_reg
    register32_we #(.WIDTH(WIDTH)) u_reg (
      .clk  (clk),
      .rst  (reset),
      .i_we (w_we_onehot[gi]),
      .i_d  (bus.write_data),
      .o_q  (w_words[gi])
    );
  end

  mux32to1by32 #(.WIDTH(WIDTH)) u_mux1 (
    .i_words (w_words),
    .i_sel   (bus.read_addr1),
    .o_y     (w_mux1)
  );

  mux32to1by32 #(.WIDTH(WIDTH)) u_mux2 (
    .i_words (w_words),
    .i_sel   (bus.read_addr2),
    .o_y     (w_mux2)
  );

`ifdef REGFILE_BYPASS_EN
  // Bypass is held off during reset so reads stay zero while reset is asserted.
  assign w_byp1 = ~reset & w_wr_valid & (bus.write_addr == bus.read_addr1);
  assign w_byp2 = ~reset & w_wr_valid & (bus.write_addr == bus.read_addr2);
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
`endif

  assign bus.read_data1 = w_byp1 ? bus.write_data : w_mux1;
  assign bus.read_data2 = w_byp2 ? bus.write_data : w_mux2;
  assign bus.busy1      = r_busy[bus.read_addr1] & ~w_byp1;
  assign bus.busy2      = r_busy[bus.read_addr2] & ~w_byp2;

  // A reserve landing on the register being written this edge is not a WAW hazard.
  assign w_rsv_hit_wr = bus.write_en & (bus.write_addr == bus.reserve_addr);
  assign w_conflict   = bus.reserve_en & (bus.reserve_addr != REG_ZERO)
                      & r_busy[bus.reserve_addr] & ~w_rsv_hit_wr;
  assign w_rsv_accept = bus.reserve_en & (bus.reserve_addr != REG_ZERO) & ~w_conflict;
  assign w_rsv_onehot = w_rsv_accept ? addr_onehot(bus.reserve_addr) : '0;
  assign w_clear_set  = w_wr_valid & r_busy[bus.write_addr];

  assign bus.reserve_conflict = w_conflict;
  assign bus.pending_count    = r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_we_onehot) | w_rsv_onehot;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      case ({w_rsv_accept, w_clear_set})
        2'b10: if (r_count != CNT_MAX) r_count <= r_count + CNT_W'(1);
        2'b01: if (r_count != '0)      r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed scenarios with literal expectations, then random traffic
// compared every cycle against an array-based model of the register file and scoreboard.
module tb_regfile_scoreboard;
  import regfile_scoreboard_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  regfile_scoreboard_if bus ();

  regfile_scoreboard dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] m_regs [32];
  bit          m_busy [32];

  function automatic bit m_conflict();
    return bus.reserve_en && (bus.reserve_addr != 5'd0) && m_busy[bus.reserve_addr]
           && !(bus.write_en && (bus.write_addr == bus.reserve_addr));
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] a);
    if (reset || a == 5'd0) return 32'd0;
    if (BYP && bus.write_en && bus.write_addr == a) return bus.write_data;
    return m_regs[a];
  endfunction

  function automatic logic m_busy_out(input logic [4:0] a);
    if (reset) return 1'b0;
    return m_busy[a] && !(BYP && bus.write_en && bus.write_addr == a);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] <= 32'd0;
        m_busy[i] <= 1'b0;
      end
    end else begin
      if (bus.reserve_en && bus.reserve_addr != 5'd0 && !m_conflict())
        m_busy[bus.reserve_addr] <= 1'b1;
      if (bus.write_en && bus.write_addr != 5'd0) begin
        m_regs[bus.write_addr] <= bus.write_data;
        if (!(bus.reserve_en && bus.reserve_addr == bus.write_addr && !m_conflict()))
          m_busy[bus.write_addr] <= 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("rd1",      bus.read_data1, m_rd(bus.read_addr1));
    check("rd2",      bus.read_data2, m_rd(bus.read_addr2));
    check("busy1",    32'(bus.busy1), 32'(m_busy_out(bus.read_addr1)));
    check("busy2",    32'(bus.busy2), 32'(m_busy_out(bus.read_addr2)));
    check("conflict", 32'(bus.reserve_conflict), reset ? 32'd0 : 32'(m_conflict()));
    check("count",    32'(bus.pending_count), 32'(m_count()));
  end

  task automatic cyc(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic re, input logic [4:0] ra,
                     input logic [4:0] a1, input logic [4:0] a2);
    @(posedge clk);
    #1;
    bus.write_en     = we;
    bus.write_addr   = wa;
    bus.write_data   = wd;
    bus.reserve_en   = re;
    bus.reserve_addr = ra;
    bus.read_addr1   = a1;
    bus.read_addr2   = a2;
    @(negedge clk);
  endtask

  initial begin
    bus.write_en = 1'b0; bus.write_addr = '0; bus.write_data = '0;
    bus.reserve_en = 1'b0; bus.reserve_addr = '0;
    bus.read_addr1 = 5'd5; bus.read_addr2 = 5'd7;

    @(negedge clk);
    check("rst_rd1",   bus.read_data1, 32'd0);
    check("rst_busy2", 32'(bus.busy2), 32'd0);
    check("rst_count", 32'(bus.pending_count), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Write then read back; writes to r0 are dropped.
    cyc(1, 5, 32'hDEADBEEF, 0, 0, 5, 0);
    check("wr5_same",  bus.read_data1, BYP ? 32'hDEADBEEF : 32'd0);
    cyc(0, 0, 0, 0, 0, 5, 0);
    check("wr5_next",  bus.read_data1, 32'hDEADBEEF);
    cyc(1, 0, 32'h1234, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("r0_zero",   bus.read_data1, 32'd0);

    // Reserve r7, then clear it with a write.
    cyc(0, 0, 0, 1, 7, 0, 7);
    check("rsv7_pre",  32'(bus.busy2), 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 7);
    check("rsv7_busy", 32'(bus.busy2), 32'd1);
    check("rsv7_cnt",  32'(bus.pending_count), 32'd1);
    cyc(1, 7, 32'h55, 0, 0, 0, 7);
    check("wr7_busy",  32'(bus.busy2), BYP ? 32'd0 : 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 7);
    check("wr7_clr",   32'(bus.busy2), 32'd0);
    check("wr7_cnt",   32'(bus.pending_count), 32'd0);
    check("wr7_data",  bus.read_data2, 32'h55);

    // WAW conflict on r9, then write+reserve on the same edge.
    cyc(0, 0, 0, 1, 9, 9, 0);
    cyc(0, 0, 0, 1, 9, 9, 0);
    check("waw_conf",  32'(bus.reserve_conflict), 32'd1);
    check("waw_cnt",   32'(bus.pending_count), 32'd1);
    cyc(1, 9, 32'h99, 1, 9, 9, 0);
    check("wr_rsv_conf", 32'(bus.reserve_conflict), 32'd0);
    cyc(0, 0, 0, 0, 0, 9, 0);
    check("wr_rsv_busy", 32'(bus.busy1), 32'd1);
    check("wr_rsv_data", bus.read_data1, 32'h99);
    check("wr_rsv_cnt",  32'(bus.pending_count), 32'd1);
    cyc(1, 9, 32'h0, 0, 0, 0, 0);

    // Same-cycle write and read of r3.
    cyc(1, 3, 32'h11, 0, 0, 0, 0);
    cyc(1, 3, 32'hA5A5A5A5, 0, 0, 3, 0);
    check("byp_rd1",   bus.read_data1, BYP ? 32'hA5A5A5A5 : 32'h11);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      bus.write_en     = ($urandom_range(0, 9) < 4);
      bus.write_addr   = 5'($urandom_range(0, 31));
      bus.write_data   = $urandom;
      bus.reserve_en   = ($urandom_range(0, 9) < 5);
      bus.reserve_addr = 5'($urandom_range(0, 31));
      bus.read_addr1   = 5'($urandom_range(0, 31));
      bus.read_addr2   = ($urandom_range(0, 3) == 0) ? bus.write_addr : 5'($urandom_range(0, 31));
    end

    // Asynchronous reset mid-cycle with busy bits set.
    cyc(0, 0, 0, 1, 12, 12, 12);
    cyc(0, 0, 0, 0, 0, 12, 12);
    check("pre_rst_busy", 32'(bus.busy1), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_rd1",   bus.read_data1, 32'd0);
    check("arst_rd2",   bus.read_data2, 32'd0);
    check("arst_busy1", 32'(bus.busy1), 32'd0);
    check("arst_busy2", 32'(bus.busy2), 32'd0);
    check("arst_cnt",   32'(bus.pending_count), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Fill the scoreboard r1..r31, then poke r0 and r31.
    for (int r = 1; r < 32; r++) cyc(0, 0, 0, 1, 5'(r), 5'(r), 0);
    cyc(0, 0, 0, 0, 0, 31, 0);
    check("fill_cnt",   32'(bus.pending_count), 32'd31);
    cyc(0, 0, 0, 1, 0, 0, 0);
    check("r0_rsv_conf", 32'(bus.reserve_conflict), 32'd0);
    cyc(0, 0, 0, 1, 31, 0, 0);
    check("r31_conf",   32'(bus.reserve_conflict), 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("fill_hold",  32'(bus.pending_count), 32'd31);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
